extbus_if: RTL



---
 rtl/extbus_if.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/extbus_if.sv
// External 6502-style bus bridge into the clk25 domain.
// Synchronises the bus strobes, address and data through equal-depth pipelines,
// then tracks each access with a small FSM. Completed accesses produce
// single-cycle register-file write/read strobes; overlapping strobes produce bus_err.
module extbus_if #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_ACTIVE  = 1
) (
  input  logic       clk25,
  input  logic       rst_n,
  input  logic       extbus_cs_n,
  input  logic       extbus_rd_n,
  input  logic       extbus_wr_n,
  input  logic [4:0] extbus_a,
  input  logic [7:0] extbus_d_in,
  output logic       extbus_d_oe,
  output logic [4:0] reg_addr,
  output logic [7:0] reg_wrdata,
  output logic       reg_write,
  output logic       reg_read,
  output logic       bus_err,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, WR_ACT, RD_ACT} state_t;

  localparam logic [1:0] MIN_CNT = 2'(MIN_ACTIVE);

  logic                   wr_act, rd_act;
  logic [SYNC_STAGES-1:0] wr_sync, rd_sync;
  logic [4:0]             a_sync [SYNC_STAGES];
  logic [7:0]             d_sync [SYNC_STAGES];
  logic                   wr_s, rd_s;
  logic [4:0]             a_s;
  logic [7:0]             d_s;
  logic                   wr_q, rd_q;
  logic [1:0]             cnt;
  state_t                 state;

  assign wr_act      = !extbus_cs_n && !extbus_wr_n;
  assign rd_act      = !extbus_cs_n && !extbus_rd_n;
  assign extbus_d_oe = rd_act;

  assign wr_s = wr_sync[SYNC_STAGES-1];
  assign rd_s = rd_sync[SYNC_STAGES-1];
  assign a_s  = a_sync[SYNC_STAGES-1];
  assign d_s  = d_sync[SYNC_STAGES-1];

  assign busy = (state != IDLE);

  // Equal-depth synchronisers keep address/data aligned with their strobe
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      wr_sync <= '0;
      rd_sync <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        a_sync[i] <= '0;
        d_sync[i] <= '0;
      end
    end else begin
      wr_sync   <= {wr_sync[SYNC_STAGES-2:0], wr_act};
      rd_sync   <= {rd_sync[SYNC_STAGES-2:0], rd_act};
      a_sync[0] <= extbus_a;
      d_sync[0] <= extbus_d_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        a_sync[i] <= a_sync[i-1];
        d_sync[i] <= d_sync[i-1];
      end
    end
  end

  // Access FSM: latch on entry, emit end strobe on deassertion, flag overlaps
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      reg_addr   <= '0;
      reg_wrdata <= '0;
      reg_write  <= 1'b0;
      reg_read   <= 1'b0;
      bus_err    <= 1'b0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
    end else begin
      reg_write <= 1'b0;
      reg_read  <= 1'b0;
      bus_err   <= 1'b0;
      wr_q      <= wr_s;
      rd_q      <= rd_s;
      case (state)
        IDLE: begin
          if (wr_s) begin
            state      <= WR_ACT;
            reg_addr   <= a_s;
            reg_wrdata <= d_s;
            cnt        <= 2'd1;
            bus_err    <= rd_s;
          end else if (rd_s) begin
            state    <= RD_ACT;
            reg_addr <= a_s;
            cnt      <= 2'd1;
          end
        end
        WR_ACT: begin
          if (wr_s) begin
            // data settles late on the 6502, so the last active sample wins
            reg_wrdata <= d_s;
            if (cnt < MIN_CNT) cnt <= cnt + 2'd1;
            if (rd_s && !rd_q) bus_err <= 1'b1;
          end else begin
            reg_write <= (cnt >= MIN_CNT);
            if (rd_s) begin
              state    <= RD_ACT;
              reg_addr <= a_s;
              cnt      <= 2'd1;
            end else begin
              state <= IDLE;
            end
          end
        end
        RD_ACT: begin
          if (rd_s) begin
            if (cnt < MIN_CNT) cnt <= cnt + 2'd1;
            if (wr_s && !wr_q) bus_err <= 1'b1;
          end else begin
            reg_read <= (cnt >= MIN_CNT);
            if (wr_s) begin
              state      <= WR_ACT;
              reg_addr   <= a_s;
              reg_wrdata <= d_s;
              cnt        <= 2'd1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
